// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the EX/MEM memory op into one request/grant/response
// transaction on the data-memory port, stalling the pipeline until it completes.
module mem_stage_lsu #(
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              misaligned,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   ld_data_q, ld_data_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic [OFF_W-1:0]    off_q, off_d;

    logic [1:0]          req_size;
    logic [OFF_W-1:0]    req_off;
    logic                size_mis;
    logic [STRB_W-1:0]   strb_base;
    logic [DATA_W-1:0]   ld_shift;
    logic [DATA_W-1:0]   ld_ext;

    assign req_size = req_funct3[1:0];
    assign req_off  = req_addr[OFF_W-1:0];

    always_comb begin
        size_mis  = 1'b0;
        strb_base = '1;
        unique case (req_size)
            2'd0: begin
                size_mis  = 1'b0;
                strb_base = STRB_W'(1);
            end
            2'd1: begin
                size_mis  = req_off[0];
                strb_base = STRB_W'(3);
            end
            2'd2: begin
                size_mis  = |req_off[1:0];
                strb_base = STRB_W'(15);
            end
            default: begin
                size_mis  = |req_off;
                strb_base = '1;
            end
        endcase
    end

    assign misaligned = !reset && req_valid && (state_q == IDLE) && size_mis;
    assign stall      = !reset && req_valid && !misaligned && (state_q != DONE);

    // Memory returns the whole aligned word; bring the addressed lane down to bit 0.
    assign ld_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        unique case (size_q)
            2'd0:    ld_ext = {{(DATA_W-8){sext_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_ext = {{(DATA_W-16){sext_q & ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    ld_ext = {{(DATA_W-32){sext_q & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so this block never infers a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        ld_data_d   = ld_data_q;
        size_d      = size_q;
        sext_d      = sext_q;
        off_d       = off_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !size_mis) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_write;
                    mem_addr_d  = {req_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_d = req_wdata << {req_off, 3'b000};
                    mem_wstrb_d = req_write ? (strb_base << req_off) : '0;
                    size_d      = req_size;
                    sext_d      = !req_funct3[2];
                    off_d       = req_off;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    ld_data_d = ld_ext;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking only, so every flop samples the pre-edge values of the others.
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            ld_data_q   <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            ld_data_q   <= ld_data_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            off_q       <= off_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: transaction-level reference model (per-op timeline plus
// lane/extension arithmetic) compared against the DUT on every falling edge.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        stall;
    logic        misaligned;
    logic [63:0] ld_data;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    mem_stage_lsu #(.DATA_W(64), .STRB_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .misaligned (misaligned),
        .ld_data    (ld_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;
    int stall_seen = 0;
    int last_rise = -1;
    logic prev_req = 1'b0;

    // Expected outputs for the current cycle, set by the stimulus process.
    bit          e_active = 1'b0;
    bit          e_chk_fields = 1'b0;
    logic        e_stall = 1'b0;
    logic        e_mis = 1'b0;
    logic        e_req = 1'b0;
    logic        e_we = 1'b0;
    logic [63:0] e_addr = '0;
    logic [63:0] e_wdata = '0;
    logic [7:0]  e_wstrb = '0;
    logic [63:0] e_ld = '0;
    logic [63:0] ld_model = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    always @(negedge clk) begin
        if (e_active) begin
            check("stall", 64'(stall), 64'(e_stall));
            check("misaligned", 64'(misaligned), 64'(e_mis));
            check("mem_req", 64'(mem_req), 64'(e_req));
            check("ld_data", ld_data, e_ld);
            if (e_req || e_chk_fields) begin
                check("mem_we", 64'(mem_we), 64'(e_we));
                check("mem_addr", mem_addr, e_addr);
                check("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
            end
            if (e_chk_fields || (e_req && e_we))
                check("mem_wdata", mem_wdata, e_wdata);
            if (stall === 1'b1) stall_seen++;
            if (mem_req === 1'b1 && prev_req !== 1'b1) last_rise = cyc_no;
            prev_req = mem_req;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [63:0] a);
        return (a % 64'(nbytes(f3))) != 0;
    endfunction

    function automatic logic [63:0] load_result(input logic [2:0] f3, input logic [63:0] a,
                                                input logic [63:0] rd);
        int nb;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        nb  = nbytes(f3);
        off = int'(a % 64'd8);
        v   = rd >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic rand_bus();
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            req_addr  = {$urandom, $urandom};
            rand_bus();
            e_stall = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_ld = ld_model;
            cyc();
        end
    endtask

    task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int gw, input int rw);
        int off;
        int nb;
        int total;
        logic [63:0] new_ld;
        off = int'(a % 64'd8);
        nb  = nbytes(f3);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (is_mis(f3, a)) begin
            rand_bus();
            e_stall = 1'b0; e_mis = 1'b1; e_req = 1'b0; e_ld = ld_model;
            cyc();
            return;
        end
        total   = wr ? 3 + gw : 4 + gw + rw;
        e_we    = wr;
        e_addr  = a - 64'(off);
        e_wstrb = wr ? 8'(((1 << nb) - 1) << off) : 8'h00;
        e_wdata = wd << (8 * off);
        new_ld  = load_result(f3, a, rd);
        for (int k = 0; k < total; k++) begin
            e_stall = (k != total - 1);
            e_mis   = 1'b0;
            e_req   = (k >= 1 && k <= 1 + gw);
            mem_gnt = e_req ? (k == 1 + gw) : 1'($urandom_range(0, 1));
            if (!wr && k >= 2 + gw && k <= 2 + gw + rw) begin
                mem_rvalid = (k == 2 + gw + rw);
                mem_rdata  = mem_rvalid ? rd : {$urandom, $urandom};
            end else begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = {$urandom, $urandom};
            end
            if (!wr && k == total - 1) ld_model = new_ld;
            e_ld = ld_model;
            cyc();
        end
    endtask

    initial begin
        int c0;
        logic [2:0] f3;
        logic [63:0] a;
        bit wr;

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011;
        req_addr = 64'h4; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc();
        // Reset held with a misaligned request pending: everything must read as reset values.
        e_active = 1'b1; e_chk_fields = 1'b1;
        e_stall = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0; e_ld = '0;
        cyc();
        reset = 1'b0;
        idle(1);
        e_chk_fields = 1'b0;

        // LW from 0x1004: upper word sign-extended.
        stall_seen = 0;
        run_txn(1'b0, 3'b010, 64'h1004, '0, 64'h8000_0001_DEAD_BEEF, 0, 0);
        check("lw_literal", ld_data, 64'hFFFF_FFFF_8000_0001);
        check("lw_stall_cycles", 64'(stall_seen), 64'd3);
        idle(1);

        // LBU / LB from 0x2007.
        run_txn(1'b0, 3'b100, 64'h2007, '0, 64'hAB00_0000_0000_0000, 1, 2);
        check("lbu_literal", ld_data, 64'h0000_0000_0000_00AB);
        run_txn(1'b0, 3'b000, 64'h2007, '0, 64'hAB00_0000_0000_0000, 0, 1);
        check("lb_literal", ld_data, 64'hFFFF_FFFF_FFFF_FFAB);

        // SH to 0x3002 with grant held off 3 cycles.
        stall_seen = 0;
        run_txn(1'b1, 3'b001, 64'h3002, 64'h1234, '0, 3, 0);
        check("sh_stall_cycles", 64'(stall_seen), 64'd5);
        check("sh_ld_held", ld_data, 64'hFFFF_FFFF_FFFF_FFAB);

        // SD to 0x4004: misaligned, no memory access.
        stall_seen = 0;
        run_txn(1'b1, 3'b011, 64'h4004, 64'h55, '0, 0, 0);
        check("sd_mis_stall_cycles", 64'(stall_seen), 64'd0);
        idle(2);

        // Reset while waiting for a response, with a stray rvalid in that cycle and after.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h5000;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        e_stall = 1'b1; e_mis = 1'b0; e_req = 1'b0; e_ld = ld_model;
        cyc();
        mem_gnt = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 64'h5000; e_wstrb = 8'h00;
        cyc();
        mem_gnt = 1'b0; reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        e_stall = 1'b0; e_req = 1'b0;
        cyc();
        reset = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b1;
        ld_model = '0; e_ld = '0; e_chk_fields = 1'b1;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        cyc();
        e_chk_fields = 1'b0;
        check("rst_ld_literal", ld_data, 64'h0);
        idle(1);

        // LD then SB back-to-back: second request rises two cycles after the first DONE.
        c0 = cyc_no;
        run_txn(1'b0, 3'b011, 64'h6008, '0, 64'h0123_4567_89AB_CDEF, 0, 1);
        run_txn(1'b1, 3'b000, 64'h6003, 64'hA5, '0, 0, 0);
        check("b2b_req_rise", 64'(last_rise), 64'(c0 + 6));
        check("ld_literal", ld_data, 64'h0123_4567_89AB_CDEF);

        // Randomized mix of loads and stores with random grant/response latency.
        for (int t = 0; t < 200; t++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                a = a - (a % 64'(nbytes(f3)));
            run_txn(wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)));
        end

        e_active = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined core. It turns the memory operation held in EX/MEM into a request/grant/response transaction on the data-memory port. It stalls the pipeline while the transaction is outstanding. It delivers an aligned, sign- or zero-extended load result to the MEM/WB register's read-data input. One transaction is outstanding at a time; stores complete at grant, loads complete at response.

## Interface

- DATA_W, 64: data and address width (RV64).
- STRB_W, DATA_W/8: byte-strobe width.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EX/MEM holds a load or store this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU (stores use 000–011)
- req_addr  in  DATA_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
- misaligned  out  1  address not aligned to access size; no memory access made
- ld_data  out  DATA_W  extended load result, valid when state is DONE
- mem_req  out  1  request valid
- mem_we  out  1  write enable
- mem_addr  out  DATA_W  req_addr with bits [2:0] cleared
- mem_wdata  out  DATA_W  store data shifted into byte lanes
- mem_wstrb  out  STRB_W  byte enables (all 0 for loads)
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  aligned 64-bit read word

## Operation

- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - req_valid && !misaligned → latch op, size, addr[2:0], mem_* fields; go to REQ.
  - Otherwise stay in IDLE.
- REQ: mem_req=1; fields held stable until mem_gnt.
  - mem_gnt && store → DONE.
  - mem_gnt && load → RESP.
- RESP: wait for mem_rvalid. On rvalid, ld_data ← extend(mem_rdata >> 8*off); go to DONE.
- DONE: one cycle, stall=0; go to IDLE.
- stall = req_valid && !misaligned && state≠DONE, all while reset=0.
- misaligned = req_valid && state==IDLE && size-misaligned, while reset=0:
  - H: off[0]≠0
  - W: off[1:0]≠0
  - D: off≠0
  - B: never misaligned
- Store lanes:
  - mem_wdata = req_wdata << 8*off
  - mem_wstrb = B: 0x01<<off, H: 0x03<<off, W: 0x0F<<off, D: 0xFF
- Load extension uses bit 7/15/31 for B/H/W. BU/HU/WU zero-extend. D passes through.
- ld_data holds its value until the next load completes. It does not clear at DONE exit.
- Ignored inputs:
  - mem_rvalid outside RESP.
  - mem_gnt outside REQ.
- reset in any state → IDLE next edge; an in-flight transaction is abandoned without completion.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, ld_data 0. stall and misaligned are 0 while reset is high.

## Timing

- Cycle N: req_valid seen in IDLE; stall=1 combinationally.
- N+1: mem_req=1 (registered).
- Store, zero-wait grant: gnt at N+1 → DONE at N+2. stall is low at N+2; EX/MEM advances at the end of N+2. Minimum store occupancy: 3 cycles.
- Load, zero-wait: gnt at N+1, rvalid at N+2 → DONE at N+3, ld_data valid at N+3. MEM/WB captures at the end of N+3. Minimum load occupancy: 4 cycles.
- Each grant wait cycle adds 1 cycle. Each response wait cycle adds 1 cycle.
- Back-to-back: a new req_valid is evaluated at DONE+1 (IDLE).
- Misaligned access: 0 extra cycles; no mem_req ever asserts.
- mem_req never asserts for two different transactions without an intervening DONE.

## Test plan

- LW, addr 0x1004, grant at N+1, rdata 0x8000_0001_xxxx_xxxx at N+2:
  - mem_addr=0x1000, mem_wstrb=0x00.
  - ld_data=0xFFFF_FFFF_8000_0001 at N+3.
  - stall high N..N+2, low at N+3.
- LBU addr 0x2007, rdata 0xAB00_..._00:
  - ld_data=0x0000_0000_0000_00AB.
  - Same op as LB gives 0xFFFF_FFFF_FFFF_FFAB.
- SH addr 0x3002, wdata 0x1234, grant delayed 3 cycles:
  - mem_wdata[31:16]=0x1234, mem_wstrb=0x0C.
  - Request fields stable across the wait.
  - DONE 1 cycle after grant; total stall 5 cycles.
- SD addr 0x4004 → misaligned=1 in cycle N, stall=0, mem_req never asserts, state stays IDLE.
- reset asserted in RESP, then stray mem_rvalid:
  - Next cycle state is IDLE; all outputs are at reset values.
  - ld_data is not updated.
- LD followed immediately by SB:
  - Second mem_req rises exactly 2 cycles after the first DONE.
  - Spurious mem_gnt and mem_rvalid in IDLE are ignored.
